pipelined_alu_adder: RTL and testbench

//  Parametrised, pipelined add/subtract unit for the CPU datapath: WIDTH-bit operands, carry chain split

---
 rtl/pipelined_alu_adder.sv | 128 ++++++++++++
 tb/tb_pipelined_alu_adder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu_adder.sv
// Pipelined add/subtract unit (ADD/SUB/ADC/SBC) with optional signed saturation and N/Z/C/V flags.
// Latency: STAGES cycles from acceptance to out_valid. Throughput is one op per cycle.
// Backpressure: stall = out_valid && !out_ready. It freezes every stage, and in_ready = !stall.
//
// Ports:
//   clk, rst             clock (rising edge) and asynchronous active-high reset
//   in_valid / in_ready  input handshake for a, b, op, cin and sat
//   a, b                 WIDTH-bit operands
//   op                   00 ADD, 01 SUB, 10 ADC, 11 SBC
//   cin                  carry-in, used by ADC and SBC only
//   sat                  1 = clamp signed overflow to signed min/max
//   out_valid / out_ready  output handshake for y and flags
//   y, flags             result and {N,Z,C,V}
module pipelined_alu_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  localparam int SW = WIDTH / STAGES;
  // At least one intermediate register slot is kept so the array never has zero size.
  // The slot is unused when STAGES == 1.
  localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;

  // One pipeline slot. The operands are carried whole because upper slices are still
  // pending and the final stage needs the MSBs for overflow detection. The sum field
  // accumulates finished slices from the bottom up.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             sat;
  } stage_t;

  stage_t r  [NR];      // registers between stage k and stage k+1
  stage_t si [STAGES];  // stage inputs
  stage_t so [STAGES];  // stage outputs, after this stage's slice is added

  logic             stall;
  logic [WIDTH-1:0] raw;
  logic             c_fin;
  logic             v_fin;
  logic [WIDTH-1:0] y_nxt;
  logic [3:0]       flags_nxt;
  logic [SW:0]      slice_sum;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Operand preparation and the slice-by-slice carry chain.
  always_comb begin
    slice_sum = '0;

    // Subtraction is a + ~b + c0. For SUB, c0 = 1 completes the two's complement.
    // For SBC, cin = 0 means a borrow is pending.
    si[0].vld = in_valid;
    si[0].a   = a;
    si[0].b   = op[0] ? ~b : b;
    si[0].sum = '0;
    si[0].c   = op[1] ? cin : op[0];
    si[0].sat = sat;

    for (int k = 1; k < STAGES; k++) begin
      si[k] = r[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      so[k]     = si[k];
      slice_sum = {1'b0, si[k].a[k*SW +: SW]} + {1'b0, si[k].b[k*SW +: SW]}
                + {{SW{1'b0}}, si[k].c};
      so[k].sum[k*SW +: SW] = slice_sum[SW-1:0];
      so[k].c               = slice_sum[SW];
    end
  end

  // Final stage: flags and saturation. C and V always describe the unsaturated sum.
  // N and Z describe the value actually delivered on y.
  always_comb begin
    raw   = so[STAGES-1].sum;
    c_fin = so[STAGES-1].c;
    v_fin = (so[STAGES-1].a[WIDTH-1] == so[STAGES-1].b[WIDTH-1]) &&
            (raw[WIDTH-1] != so[STAGES-1].a[WIDTH-1]);
    y_nxt = raw;
    if (so[STAGES-1].sat && v_fin) begin
      // Overflow always moves away from the sign of a, so clamp toward that sign.
      y_nxt = so[STAGES-1].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
    end
    flags_nxt = {y_nxt[WIDTH-1], (y_nxt == '0), c_fin, v_fin};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NR; k++) begin
        r[k] <= '0;
      end
      out_valid <= 1'b0;
      y         <= '0;
      flags     <= '0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        r[k] <= so[k];
      end
      out_valid <= so[STAGES-1].vld;
      // Bubbles leave the last result on y/flags untouched.
      if (so[STAGES-1].vld) begin
        y     <= y_nxt;
        flags <= flags_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_alu_adder.sv
// Self-checking bench for pipelined_alu_adder at WIDTH=8, STAGES=2.
// It applies a vector table of single ops, checks a stalled back-to-back burst and
// checks a reset taken while ops are in flight.
module tb_pipelined_alu_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         cin;
  logic         sat;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [3:0]   flags;

  int checks = 0;
  int errors = 0;

  pipelined_alu_adder #(.WIDTH(W), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sat;
    logic [W-1:0] y;
    logic [3:0]   f;   // {N,Z,C,V}
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  function automatic vec_t mk(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic c, input logic s, input logic [W-1:0] ey, input logic [3:0] ef);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.cin = c; v.sat = s; v.y = ey; v.f = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    op = v.op; a = v.a; b = v.b; cin = v.cin; sat = v.sat;
  endtask

  // Send one op, wait for its result and check the latency, y and flags.
  task automatic send_one(input int idx);
    int n;
    @(posedge clk); #1;
    drive(vt[idx]);
    in_valid = 1'b1;
    #1;
    chk($sformatf("v%0d in_ready", idx), {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("v%0d latency", idx), n, 32'd2);
    chk($sformatf("v%0d y", idx), {24'b0, y}, {24'b0, vt[idx].y});
    chk($sformatf("v%0d flags", idx), {28'b0, flags}, {28'b0, vt[idx].f});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, recv, cyc, stalls;
    logic exp_rdy;

    //            op     a      b      cin   sat   y      {N,Z,C,V}
    vt[0]  = mk(2'b00, 8'd100, 8'd27, 1'b0, 1'b0, 8'h7F, 4'b0000);
    vt[1]  = mk(2'b00, 8'd100, 8'd28, 1'b0, 1'b0, 8'h80, 4'b1001);
    vt[2]  = mk(2'b00, 8'd100, 8'd28, 1'b0, 1'b1, 8'h7F, 4'b0001);
    vt[3]  = mk(2'b01, 8'd5,   8'd7,  1'b0, 1'b0, 8'hFE, 4'b1000);
    vt[4]  = mk(2'b01, 8'd7,   8'd7,  1'b0, 1'b0, 8'h00, 4'b0110);
    vt[5]  = mk(2'b01, 8'h80,  8'h01, 1'b0, 1'b1, 8'h80, 4'b1011);
    vt[6]  = mk(2'b10, 8'hFF,  8'h00, 1'b1, 1'b0, 8'h00, 4'b0110);
    vt[7]  = mk(2'b11, 8'h10,  8'h01, 1'b0, 1'b0, 8'h0E, 4'b0010);
    vt[8]  = mk(2'b00, 8'hFF,  8'h01, 1'b0, 1'b0, 8'h00, 4'b0110);
    vt[9]  = mk(2'b00, 8'h01,  8'h01, 1'b1, 1'b0, 8'h02, 4'b0000); // cin ignored by ADD
    vt[10] = mk(2'b01, 8'h03,  8'h01, 1'b0, 1'b0, 8'h02, 4'b0010); // cin ignored by SUB
    vt[11] = mk(2'b00, 8'h80,  8'h80, 1'b0, 1'b1, 8'h80, 4'b1011);
    vt[12] = mk(2'b00, 8'h80,  8'h80, 1'b0, 1'b0, 8'h00, 4'b0111);
    vt[13] = mk(2'b10, 8'h7F,  8'h00, 1'b1, 1'b0, 8'h80, 4'b1001);
    vt[14] = mk(2'b11, 8'h00,  8'h00, 1'b0, 1'b0, 8'hFF, 4'b1000);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0; cin = 1'b0; sat = 1'b0;

    // Reset state.
    #12;
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset y", {24'b0, y}, 32'd0);
    chk("reset flags", {28'b0, flags}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", {31'b0, in_ready}, 32'd1);

    // Vector table, one op at a time.
    for (int i = 0; i < NV; i++) begin
      send_one(i);
    end

    // Six back-to-back ops, with out_ready low for three cycles in the middle.
    sent = 0; recv = 0; cyc = 0; stalls = 0;
    while (recv < 6 && cyc < 40) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 6) begin
        drive(vt[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_rdy = !(out_valid && !out_ready);
      chk($sformatf("burst c%0d in_ready", cyc), {31'b0, in_ready}, {31'b0, exp_rdy});
      if (!in_ready) stalls++;
      if (out_valid && out_ready) begin
        chk($sformatf("burst r%0d y", recv), {24'b0, y}, {24'b0, vt[recv].y});
        chk($sformatf("burst r%0d flags", recv), {28'b0, flags}, {28'b0, vt[recv].f});
        recv++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("burst results received", recv, 32'd6);
    chk("burst stall cycles", stalls, 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("burst no dup %0d", i), {31'b0, out_valid}, 32'd0);
    end

    // Reset asynchronously with two ops in flight.
    @(posedge clk); #1;
    drive(vt[0]); in_valid = 1'b1;
    @(posedge clk); #1;
    drive(vt[3]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("async reset y", {24'b0, y}, 32'd0);
    chk("async reset flags", {28'b0, flags}, 32'd0);
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("no stale %0d", i), {31'b0, out_valid}, 32'd0);
    end
    send_one(7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
